// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with 2-bit saturating counters for IF-stage next-PC prediction.
// Optional statistics counters are compiled in with `define BP_STATS_EN.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  output logic              mispredict,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr_d;

  // Word-aligned PCs: the two low bits never take part in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  always_comb begin
    lk_idx      = lookup_pc[IDX_W+1:2];
    lk_tag      = lookup_pc[ADDR_W-1:IDX_W+2];
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + PC_STEP;
  end

  always_comb begin
    upd_idx    = upd_pc[IDX_W+1:2];
    upd_tag    = upd_pc[ADDR_W-1:IDX_W+2];
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    mispredict = upd_valid && (upd_pred_taken != upd_taken);
    upd_ctr_d  = ctr_q[upd_idx];
    if (upd_taken) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr_d = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr_d = ctr_q[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_d;
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branches_q, mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (upd_valid) begin
      branches_q <= branches_q + 32'd1;
      if (mispredict) mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// checked each cycle against an array-based behavioural BTB model.
module tb_branch_predictor;

  localparam int E = 64;
`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic        mispredict;
  logic [31:0] stat_branches, stat_mispredicts;

  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_W(32), .ENTRIES(E)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .mispredict(mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Behavioural model: one record per set, counter held as an integer 0..3.
  bit          m_valid [E];
  int unsigned m_tag   [E];
  logic [31:0] m_tgt   [E];
  int          m_ctr   [E];
  int unsigned m_br = 0, m_mp = 0;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % E);
  endfunction
  function automatic int unsigned mtag(input logic [31:0] pc);
    return pc / (4 * E);
  endfunction
  function automatic bit mhit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction
  function automatic bit mpred(input logic [31:0] pc);
    return mhit(pc) && (m_ctr[midx(pc)] >= 2);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < E; i++) begin
        m_valid[i] <= 1'b0;
        m_tag[i]   <= 0;
        m_tgt[i]   <= '0;
        m_ctr[i]   <= 1;
      end
      m_br <= 0;
      m_mp <= 0;
    end else if (upd_valid) begin
      m_br <= m_br + 1;
      if (upd_pred_taken != upd_taken) m_mp <= m_mp + 1;
      if (mhit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[midx(upd_pc)] <= (m_ctr[midx(upd_pc)] == 3) ? 3 : m_ctr[midx(upd_pc)] + 1;
          m_tgt[midx(upd_pc)] <= upd_target;
        end else begin
          m_ctr[midx(upd_pc)] <= (m_ctr[midx(upd_pc)] == 0) ? 0 : m_ctr[midx(upd_pc)] - 1;
        end
      end else if (upd_taken) begin
        m_valid[midx(upd_pc)] <= 1'b1;
        m_tag[midx(upd_pc)]   <= mtag(upd_pc);
        m_tgt[midx(upd_pc)]   <= upd_target;
        m_ctr[midx(upd_pc)]   <= 2;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      automatic bit          e_hit   = mhit(lookup_pc);
      automatic bit          e_taken = mpred(lookup_pc);
      automatic logic [31:0] e_tgt   = e_taken ? m_tgt[midx(lookup_pc)] : lookup_pc + 32'd4;
      check("pred_hit",    {31'd0, pred_hit},    {31'd0, e_hit});
      check("pred_taken",  {31'd0, pred_taken},  {31'd0, e_taken});
      check("pred_target", pred_target, e_tgt);
      check("mispredict",  {31'd0, mispredict},
            {31'd0, upd_valid && (upd_pred_taken != upd_taken)});
      check("stat_branches",    stat_branches,    STATS ? m_br : 32'd0);
      check("stat_mispredicts", stat_mispredicts, STATS ? m_mp : 32'd0);
    end
  end

  task automatic drive(input logic r, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                       input logic upt);
    @(posedge clk);
    #1;
    rst = r; lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg; upd_pred_taken = upt;
  endtask

  task automatic idle(input logic [31:0] lpc);
    drive(1'b0, lpc, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    drive(1'b0, pc, 1'b1, pc, t, tg, mpred(pc));
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    @(posedge clk);
    #1 armed = 1'b1;
    // Reset held: lookup must miss and fall through to pc+4.
    drive(1'b1, 32'h40, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("rst_hit", {31'd0, pred_hit}, 32'd0);
    check("rst_target", pred_target, 32'h44);
    idle(32'h40);
    @(negedge clk);
    check("post_rst_hit", {31'd0, pred_hit}, 32'd0);
    check("post_rst_taken", {31'd0, pred_taken}, 32'd0);
    check("post_rst_target", pred_target, 32'h44);
    check("post_rst_stats", stat_branches, 32'd0);

    // First allocation; same-cycle lookup sees the old (empty) entry.
    drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    @(negedge clk);
    check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    check("alloc_no_bypass", {31'd0, pred_hit}, 32'd0);
    idle(32'h40);
    @(negedge clk);
    check("alloc_hit", {31'd0, pred_hit}, 32'd1);
    check("alloc_taken", {31'd0, pred_taken}, 32'd1);
    check("alloc_target", pred_target, 32'h80);

    // Saturate, decay to weak-NT, then retrain.
    repeat (3) train(32'h40, 1'b1, 32'h80);
    idle(32'h40);
    @(negedge clk);
    check("sat_taken", {31'd0, pred_taken}, 32'd1);
    repeat (2) train(32'h40, 1'b0, 32'h0);
    idle(32'h40);
    @(negedge clk);
    check("weak_nt_hit", {31'd0, pred_hit}, 32'd1);
    check("weak_nt_taken", {31'd0, pred_taken}, 32'd0);
    check("weak_nt_target", pred_target, 32'h44);
    train(32'h40, 1'b1, 32'h80);
    idle(32'h40);
    @(negedge clk);
    check("retrain_taken", {31'd0, pred_taken}, 32'd1);

    // Aliasing: 0x140 shares the set with 0x40.
    train(32'h140, 1'b1, 32'h200);
    idle(32'h40);
    @(negedge clk);
    check("alias_evict", {31'd0, pred_hit}, 32'd0);
    idle(32'h140);
    @(negedge clk);
    check("alias_hit", {31'd0, pred_hit}, 32'd1);
    check("alias_target", pred_target, 32'h200);

    // Stats: 10 resolved branches after reset, the first 3 mispredicted.
    drive(1'b1, 32'h0, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      automatic logic t = logic'(k % 2);
      drive(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(4 * k), t, 32'h2000, (k < 3) ? ~t : t);
    end
    idle(32'h0);
    @(negedge clk);
    check("stat_br_10", stat_branches, STATS ? 32'd10 : 32'd0);
    check("stat_mp_3", stat_mispredicts, STATS ? 32'd3 : 32'd0);

    // Reset in the middle of a training burst wins over the concurrent update.
    for (int k = 0; k < 8; k++) train(32'(k * 4), 1'b1, 32'h3000 + 32'(k * 4));
    drive(1'b1, 32'h0, 1'b1, 32'h4, 1'b1, 32'h5000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      idle(32'(k * 4));
      @(negedge clk);
      check("burst_rst_miss", {31'd0, pred_hit}, 32'd0);
    end
    check("burst_rst_stats", stat_branches, 32'd0);

    // Randomized traffic over a small PC pool to force hits and aliasing.
    for (int n = 0; n < 3000; n++) begin
      automatic logic [31:0] upc = rand_pc();
      automatic logic        ut  = logic'($urandom_range(0, 1));
      automatic logic        upt = ($urandom_range(0, 1) == 1) ? mpred(upc)
                                                               : logic'($urandom_range(0, 1));
      drive(($urandom_range(0, 199) == 0), rand_pc(), logic'($urandom_range(0, 3) != 0),
            upc, ut, {$urandom, 2'b00} >> 2 << 2, upt);
    end
    idle(32'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
